mor1kx_rf_port_arbiter: RTL
===========================

// Module: mor1kx_rf_port_arbiter
// PURPOSE
//  Owns the single GPR-RAM write port and the SPR-side GPR read port of the cappuccino register file.
//  Arbitrates pipeline writeback against SPR-bus GPR accesses (debug unit, fast contexts, shadow GPRs).
//  Sequences the multi-cycle SPR read handshake.
//  Optionally runs a post-reset hardware clear of every RF word while stalling the pipeline.
// PARAMETERS
//  OPTION_OPERAND_WIDTH      32  data width of GPRs
//  OPTION_RF_ADDR_WIDTH      5   pipeline GPR address width
//  OPTION_RF_NUM_SHADOW_GPR  0   shadow GPR sets; RF_ADDR_WIDTH = calc_rf_addr_width(5-bit base, shadows)
// PORTS
//  clk              in   1     clock
//  rst              in   1     reset, synchronous, active-high
//  wb_rf_wb_i       in   1     pipeline writeback request
//  wb_rfd_adr_i     in   OPTION_RF_ADDR_WIDTH  writeback address (zero-extended to RF_ADDR_WIDTH)
//  result_i         in   OPTION_OPERAND_WIDTH  writeback data
//  padv_ctrl_i      in   1     ctrl stage advancing; blocks SPR read issue
//  spr_bus_addr_i   in   16    SPR address; GPR group = addr[15:9]==7'h2
//  spr_bus_stb_i    in   1     SPR strobe
//  spr_bus_we_i     in   1     SPR write
//  spr_bus_dat_i    in   OPTION_OPERAND_WIDTH  SPR write data
//  spr_gpr_ack_o    out  1     SPR GPR access acknowledge (1-cycle pulse)
//  spr_gpr_dat_o    out  OPTION_OPERAND_WIDTH  SPR read data, valid with ack
//  rf_wren_o        out  1     RAM write enable
//  rf_wradr_o       out  RF_ADDR_WIDTH         RAM write address
//  rf_wrdat_o       out  OPTION_OPERAND_WIDTH  RAM write data
//  rf_spr_re_o      out  1     SPR-side RAM read enable
//  rf_spr_radr_o    out  RF_ADDR_WIDTH         SPR-side RAM read address (= spr_bus_addr_i[RF_ADDR_WIDTH-1:0])
//  rf_spr_dout_i    in   OPTION_OPERAND_WIDTH  SPR-side RAM read data, 1 cycle after re
//  rf_busy_o        out  1     RF unavailable; pipeline must hold padv_decode low
// BEHAVIOUR
//  States: CLEAR, IDLE, RD_WAIT, DONE.
//  Reset: state=CLEAR (macro on) or IDLE (macro off); all outputs 0 except rf_busy_o=1 in CLEAR; clear counter=0.
//  Write port priority: wb_rf_wb_i > SPR write > clear sequencer. Writeback is never delayed and is combinational passthrough.
//  SPR write (IDLE, GPR group, stb&we):
//   - no writeback: RAM write that cycle, ack in the same cycle, then go to DONE.
//   - writeback active: stay in IDLE, no ack, retry next cycle.
//  SPR read (IDLE, GPR group, stb&!we&!padv_ctrl_i): assert rf_spr_re_o, go to RD_WAIT.
//  RD_WAIT: register rf_spr_dout_i into spr_gpr_dat_o; ack pulses 1 cycle later (2-cycle read latency); go to DONE.
//  spr_gpr_dat_o holds until the next read completes.
//  DONE: no new access accepted until stb_i low, then go to IDLE; prevents double-issue on held strobe.
//  Non-GPR SPR addresses are ignored; no ack.
//  Strobe dropped in RD_WAIT: read completes, ack still pulses, then go to IDLE.
//  rst asserted in any state: go to reset state next cycle; any in-flight ack is suppressed.
// CONFIGURATION
//  MOR1KX_RF_HW_CLEAR_EN defined:
//   - CLEAR writes 0 to addresses 0..2**RF_ADDR_WIDTH-1, one per cycle.
//   - Counter stalls in any cycle wb_rf_wb_i=1.
//   - SPR accesses are not accepted (no ack) during CLEAR.
//   - After the last address is written, go to IDLE and deassert rf_busy_o in the same transition.
//   - Clear takes 2**RF_ADDR_WIDTH cycles with no stalls.
//  MOR1KX_RF_HW_CLEAR_EN undefined: no CLEAR state or counter; rf_busy_o tied 0.
// STRUCTURE
//  Package mor1kx_rf_arb_pkg:
//   - state enum.
//   - SPR_GPR_GROUP=7'h2.
//   - RF address-width helper matching calc_rf_addr_width.
//  Sub-module mor1kx_rf_clear_seq: wrapping address counter with enable, done flag; instantiated only under the macro.
//  Top level: FSM, write-port mux, read-data register.
// TESTING
//  1. Macro on, default params, reset release -> rf_wren_o high 32 cycles, addresses 0..31 with data 0; rf_busy_o falls after addr 31.
//  2. Clear in progress, wb_rf_wb_i=1 adr=5 result=0xDEADBEEF at counter=10 -> RAM writes adr 5; counter resumes at 10 next cycle.
//  3. SPR write addr 0x0403 data 0x1234 with wb_rf_wb_i=1 for 2 cycles -> no ack for 2 cycles; then write adr 3, ack, DONE until stb low.
//  4. SPR read addr 0x0407 with padv_ctrl_i=1 for 3 cycles -> no re; then re adr 7, ack 2 cycles later, spr_gpr_dat_o = RAM[7].
//  5. Non-GPR SPR access addr 0x0011, stb held 10 cycles -> no ack, no RAM access.
//  6. rst pulsed during RD_WAIT -> no ack issued; FSM in reset state next cycle; all outputs at reset values.

Source files
------------

// File: rtl/mor1kx_rf_port_arbiter_pkg.sv
// Shared types and helpers for the cappuccino RF port arbiter.
// Holds the arbiter state encoding, the SPR group of the GPR space, and
// the register-file address-width calculation used with shadow GPR sets.
package mor1kx_rf_arb_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_RD_WAIT,
        ST_DONE
    } arb_state_t;

    localparam logic [6:0] SPR_GPR_GROUP = 7'h2;

    // Shadow sets extend the RAM address above the architectural GPR index.
    function automatic int calc_rf_addr_width(input int rf_addr_width,
                                              input int rf_num_shadow_gpr);
        return rf_addr_width +
               ((rf_num_shadow_gpr == 1) ? 1 : $clog2(rf_num_shadow_gpr));
    endfunction

endpackage

// File: rtl/mor1kx_rf_port_arbiter_if.sv
// SPR-bus side of the RF port arbiter: request fields from the SPR bus
// and the GPR acknowledge/read-data return path.
interface mor1kx_rf_port_arbiter_if #(
    parameter int OPTION_OPERAND_WIDTH = 32
);
    logic [15:0]                     spr_bus_addr;
    logic                            spr_bus_stb;
    logic                            spr_bus_we;
    logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat;
    logic                            spr_gpr_ack;
    logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat;

    modport master (
        output spr_bus_addr, spr_bus_stb, spr_bus_we, spr_bus_dat,
        input  spr_gpr_ack, spr_gpr_dat
    );

    modport slave (
        input  spr_bus_addr, spr_bus_stb, spr_bus_we, spr_bus_dat,
        output spr_gpr_ack, spr_gpr_dat
    );
endinterface

// File: rtl/mor1kx_rf_clear_seq.sv
// Address sequencer for the post-reset RF hardware clear.
// Walks every RAM address once; advances only when enabled and flags the
// cycle in which the final address is being written.
module mor1kx_rf_clear_seq
    import mor1kx_rf_arb_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] cnt_d;
    logic [ADDR_W-1:0] cnt_q;

    // Next count: hold when stalled, wrap naturally after the top address.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (rst) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign addr_o = cnt_q;
    assign last_o = en_i & (&cnt_q);

endmodule

// File: rtl/mor1kx_rf_port_arbiter.sv
// Cappuccino register-file port arbiter.
// Owns the single GPR RAM write port (writeback > SPR write > clear) and the
// SPR-side read port, and sequences SPR GPR reads (2-cycle latency to ack).
// Optional feature: MOR1KX_RF_HW_CLEAR_EN enables a post-reset clear of all
// RF words, holding rf_busy_o high until the last word has been written.
module mor1kx_rf_port_arbiter
    import mor1kx_rf_arb_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH     = 32,
    parameter int OPTION_RF_ADDR_WIDTH     = 5,
    parameter int OPTION_RF_NUM_SHADOW_GPR = 0,
    localparam int RF_ADDR_WIDTH =
        calc_rf_addr_width(OPTION_RF_ADDR_WIDTH, OPTION_RF_NUM_SHADOW_GPR)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wb_rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] result_i,
    input  logic                            padv_ctrl_i,
    mor1kx_rf_port_arbiter_if.slave         spr,
    output logic                            rf_wren_o,
    output logic [RF_ADDR_WIDTH-1:0]        rf_wradr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] rf_wrdat_o,
    output logic                            rf_spr_re_o,
    output logic [RF_ADDR_WIDTH-1:0]        rf_spr_radr_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] rf_spr_dout_i,
    output logic                            rf_busy_o
);

`ifdef MOR1KX_RF_HW_CLEAR_EN
    localparam arb_state_t RESET_STATE = ST_CLEAR;
`else
    localparam arb_state_t RESET_STATE = ST_IDLE;
`endif

    arb_state_t                      state_d, state_q;
    logic                            rd_ack_d, rd_ack_q;
    logic [OPTION_OPERAND_WIDTH-1:0] rd_dat_d, rd_dat_q;

    logic                     spr_gpr_sel;
    logic                     spr_wr_req;
    logic                     spr_rd_req;
    logic                     spr_wr_go;
    logic                     spr_rd_go;
    logic                     clr_en;
    logic                     clr_last;
    logic [RF_ADDR_WIDTH-1:0] clr_addr;
    logic [RF_ADDR_WIDTH-1:0] spr_rf_adr;
    logic                     unused_addr_bits;

    assign spr_gpr_sel = (spr.spr_bus_addr[15:9] == SPR_GPR_GROUP);
    assign spr_wr_req  = spr_gpr_sel & spr.spr_bus_stb & spr.spr_bus_we;
    assign spr_rd_req  = spr_gpr_sel & spr.spr_bus_stb & ~spr.spr_bus_we;
    assign spr_rf_adr  = spr.spr_bus_addr[RF_ADDR_WIDTH-1:0];
    assign unused_addr_bits = ^spr.spr_bus_addr;

`ifdef MOR1KX_RF_HW_CLEAR_EN
    mor1kx_rf_clear_seq #(
        .ADDR_W (RF_ADDR_WIDTH)
    ) u_clear_seq (
        .clk    (clk),
        .rst    (rst),
        .en_i   (clr_en),
        .addr_o (clr_addr),
        .last_o (clr_last)
    );
`else
    assign clr_addr = '0;
    assign clr_last = 1'b0;
`endif

    // Arbiter FSM next state: SPR access acceptance, read sequencing, clear exit.
    always_comb begin
        state_d   = state_q;
        rd_ack_d  = 1'b0;
        rd_dat_d  = rd_dat_q;
        spr_wr_go = 1'b0;
        spr_rd_go = 1'b0;
        clr_en    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
`ifdef MOR1KX_RF_HW_CLEAR_EN
                // Writeback owns the port this cycle, so the sweep waits.
                clr_en = ~wb_rf_wb_i;
                if (clr_last) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_IDLE: begin
                if (spr_wr_req) begin
                    // A colliding writeback wins; the SPR write retries next cycle.
                    if (!wb_rf_wb_i) begin
                        spr_wr_go = 1'b1;
                        state_d   = ST_DONE;
                    end
                end else if (spr_rd_req && !padv_ctrl_i) begin
                    spr_rd_go = 1'b1;
                    state_d   = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                rd_dat_d = rf_spr_dout_i;
                rd_ack_d = 1'b1;
                state_d  = spr.spr_bus_stb ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                if (!spr.spr_bus_stb) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = RESET_STATE;
        endcase
        if (rst) begin
            state_d   = RESET_STATE;
            rd_ack_d  = 1'b0;
            rd_dat_d  = '0;
            spr_wr_go = 1'b0;
            spr_rd_go = 1'b0;
            clr_en    = 1'b0;
        end
    end

    // FSM and registered read-return state.
    always_ff @(posedge clk) begin
        state_q  <= state_d;
        rd_ack_q <= rd_ack_d;
        rd_dat_q <= rd_dat_d;
    end

    // Write-port mux: writeback passes straight through, then SPR write, then clear.
    always_comb begin
        rf_wren_o  = 1'b0;
        rf_wradr_o = '0;
        rf_wrdat_o = '0;
        if (wb_rf_wb_i) begin
            rf_wren_o  = 1'b1;
            rf_wradr_o = RF_ADDR_WIDTH'(wb_rfd_adr_i);
            rf_wrdat_o = result_i;
        end else if (spr_wr_go) begin
            rf_wren_o  = 1'b1;
            rf_wradr_o = spr_rf_adr;
            rf_wrdat_o = spr.spr_bus_dat;
        end else if (clr_en) begin
            rf_wren_o  = 1'b1;
            rf_wradr_o = clr_addr;
        end
    end

    assign spr.spr_gpr_ack = (spr_wr_go | rd_ack_q) & ~rst;
    assign spr.spr_gpr_dat = rd_dat_q;
    assign rf_spr_re_o     = spr_rd_go;
    assign rf_spr_radr_o   = spr_rf_adr;

`ifdef MOR1KX_RF_HW_CLEAR_EN
    assign rf_busy_o = (state_q == ST_CLEAR);
`else
    assign rf_busy_o = 1'b0;
`endif

endmodule
